// File: rtl/victim_cache_controller.sv
// Fully-associative victim cache sitting beside a direct-mapped L1.
// Lines evicted from L1 are installed here in FIFO order; an L1 miss probes
// this cache, and a hit hands the line back to L1 and drops the local copy.
// A valid+dirty victim is written back to memory before being overwritten.
//
// Handshakes: every request input (probe_valid, evict_valid, mem_resp_valid)
// is a single-cycle strobe sampled on the rising edge; every response output
// (probe_ready, evict_ack) is a single-cycle strobe; mem_req is a level held
// from entry into S_WB until the edge that samples mem_resp_valid=1.
module victim_cache_controller #(
    parameter int TAG_WIDTH  = 20,
    parameter int LINE_BYTES = 16,
    parameter int NUM_WAYS   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    probe_valid,
    input  logic [TAG_WIDTH-1:0]    probe_tag,
    output logic                    probe_hit,
    output logic [LINE_BYTES*8-1:0] probe_line,
    output logic                    probe_ready,
    input  logic                    evict_valid,
    input  logic [TAG_WIDTH-1:0]    evict_tag,
    input  logic [LINE_BYTES*8-1:0] evict_line,
    input  logic                    evict_dirty,
    output logic                    evict_ack,
    output logic                    mem_req,
    output logic                    mem_req_write,
    output logic [TAG_WIDTH-1:0]    mem_req_tag,
    output logic [LINE_BYTES*8-1:0] mem_req_wdata,
    input  logic                    mem_resp_valid,
    output logic [2:0]              o_dbg_state
);

    localparam int LINE_W = LINE_BYTES * 8;
    localparam int PTR_W  = $clog2(NUM_WAYS);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    localparam logic [2:0] S_IDLE          = 3'd0;
    localparam logic [2:0] S_PROBE_LOOKUP  = 3'd1;
    localparam logic [2:0] S_PROBE_RESP    = 3'd2;
    localparam logic [2:0] S_INSTALL_CHECK = 3'd3;
    localparam logic [2:0] S_WB            = 3'd4;
    localparam logic [2:0] S_INSTALL_WRITE = 3'd5;

    // Storage
    logic [NUM_WAYS-1:0]  r_valid;
    logic [NUM_WAYS-1:0]  r_dirty;
    logic [TAG_WIDTH-1:0] r_tag  [NUM_WAYS];
    logic [LINE_W-1:0]    r_data [NUM_WAYS];
    logic [PTR_W-1:0]     r_repl_ptr;

    logic [2:0] r_state;
    logic [2:0] w_next_state;

    // Pending requests captured while the FSM is busy
    logic                 r_ev_pend;
    logic [TAG_WIDTH-1:0] r_ev_tag;
    logic [LINE_W-1:0]    r_ev_line;
    logic                 r_ev_dirty;
    logic                 r_pr_pend;
    logic [TAG_WIDTH-1:0] r_pr_tag;

    // Install in flight, decoupled from the pending slot so a new capture
    // cannot corrupt the line being installed
    logic [TAG_WIDTH-1:0] r_ins_tag;
    logic [LINE_W-1:0]    r_ins_line;
    logic                 r_ins_dirty;

    // Probe in flight and its registered lookup result
    logic [TAG_WIDTH-1:0] r_lookup_tag;
    logic                 r_hit;
    logic [PTR_W-1:0]     r_way;
    logic [LINE_W-1:0]    r_line;

    // Victim selected for write-back
    logic [TAG_WIDTH-1:0] r_victim_tag;
    logic [LINE_W-1:0]    r_victim_data;

    logic                 w_take_live;
    logic                 w_take_pend;
    logic                 w_take_ev;
    logic                 w_hit;
    logic [PTR_W-1:0]     w_way;
    logic [LINE_W-1:0]    w_line;

    // Next-state logic and idle arbitration: live probe, pending probe, pending evict
    always_comb begin
        w_next_state = r_state;
        w_take_live  = 1'b0;
        w_take_pend  = 1'b0;
        w_take_ev    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (probe_valid) begin
                    w_take_live  = 1'b1;
                    w_next_state = S_PROBE_LOOKUP;
                end else if (r_pr_pend) begin
                    w_take_pend  = 1'b1;
                    w_next_state = S_PROBE_LOOKUP;
                end else if (r_ev_pend) begin
                    w_take_ev    = 1'b1;
                    w_next_state = S_INSTALL_CHECK;
                end
            end
            S_PROBE_LOOKUP:  w_next_state = S_PROBE_RESP;
            S_PROBE_RESP:    w_next_state = S_IDLE;
            S_INSTALL_CHECK: w_next_state = (r_valid[r_repl_ptr] && r_dirty[r_repl_ptr])
                                            ? S_WB : S_INSTALL_WRITE;
            S_WB:            if (mem_resp_valid) w_next_state = S_INSTALL_WRITE;
            S_INSTALL_WRITE: w_next_state = S_IDLE;
            default:         w_next_state = S_IDLE;
        endcase
    end

    // Tag compare across valid ways; descending scan so the lowest index wins
    always_comb begin
        w_hit  = 1'b0;
        w_way  = '0;
        w_line = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == r_lookup_tag)) begin
                w_hit  = 1'b1;
                w_way  = i[PTR_W-1:0];
                w_line = r_data[i];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Evict capture; a capture on the consuming edge keeps the slot full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ev_pend   <= 1'b0;
            r_ev_tag    <= '0;
            r_ev_line   <= '0;
            r_ev_dirty  <= 1'b0;
            r_ins_tag   <= '0;
            r_ins_line  <= '0;
            r_ins_dirty <= 1'b0;
        end else begin
            if (w_take_ev) begin
                r_ins_tag   <= r_ev_tag;
                r_ins_line  <= r_ev_line;
                r_ins_dirty <= r_ev_dirty;
            end
            if (evict_valid) begin
                r_ev_pend  <= 1'b1;
                r_ev_tag   <= evict_tag;
                r_ev_line  <= evict_line;
                r_ev_dirty <= evict_dirty;
            end else if (w_take_ev) begin
                r_ev_pend  <= 1'b0;
            end
        end
    end

    // Probe capture: serviced directly in idle, otherwise parked for later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pr_pend    <= 1'b0;
            r_pr_tag     <= '0;
            r_lookup_tag <= '0;
        end else begin
            if (probe_valid && (r_state != S_IDLE)) begin
                r_pr_pend <= 1'b1;
                r_pr_tag  <= probe_tag;
            end else if (w_take_pend) begin
                r_pr_pend <= 1'b0;
            end
            if (w_take_live)      r_lookup_tag <= probe_tag;
            else if (w_take_pend) r_lookup_tag <= r_pr_tag;
        end
    end

    // Lookup result and write-back victim registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit         <= 1'b0;
            r_way         <= '0;
            r_line        <= '0;
            r_victim_tag  <= '0;
            r_victim_data <= '0;
        end else begin
            if (r_state == S_PROBE_LOOKUP) begin
                r_hit  <= w_hit;
                r_way  <= w_way;
                r_line <= w_line;
            end
            if (r_state == S_INSTALL_CHECK) begin
                r_victim_tag  <= r_tag[r_repl_ptr];
                r_victim_data <= r_data[r_repl_ptr];
            end
        end
    end

    // Way storage: invalidate on probe hit, FIFO install at repl_ptr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_dirty    <= '0;
            r_repl_ptr <= '0;
            for (int i = 0; i < NUM_WAYS; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if ((r_state == S_PROBE_RESP) && r_hit) begin
                r_valid[r_way] <= 1'b0;
                r_dirty[r_way] <= 1'b0;
            end
            if (r_state == S_INSTALL_WRITE) begin
                r_valid[r_repl_ptr] <= 1'b1;
                r_dirty[r_repl_ptr] <= r_ins_dirty;
                r_tag[r_repl_ptr]   <= r_ins_tag;
                r_data[r_repl_ptr]  <= r_ins_line;
                r_repl_ptr          <= r_repl_ptr + PTR_ONE;
            end
        end
    end

    // Outputs decode from the registered state so they are zero outside their state
    assign probe_ready   = (r_state == S_PROBE_RESP);
    assign probe_hit     = (r_state == S_PROBE_RESP) && r_hit;
    assign probe_line    = ((r_state == S_PROBE_RESP) && r_hit) ? r_line : '0;
    assign evict_ack     = (r_state == S_INSTALL_WRITE);
    assign mem_req       = (r_state == S_WB);
    assign mem_req_write = (r_state == S_WB);
    assign mem_req_tag   = (r_state == S_WB) ? r_victim_tag  : '0;
    assign mem_req_wdata = (r_state == S_WB) ? r_victim_data : '0;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_victim_cache_controller.sv
// Directed bench for victim_cache_controller: installs, probes, write-back,
// FIFO replacement and the probe-before-install arbitration case.
module tb_victim_cache_controller;

    localparam int TW = 20;
    localparam int LW = 128;
    localparam int BUDGET = 50;

    logic          clk;
    logic          rst_n;
    logic          probe_valid;
    logic [TW-1:0] probe_tag;
    logic          probe_hit;
    logic [LW-1:0] probe_line;
    logic          probe_ready;
    logic          evict_valid;
    logic [TW-1:0] evict_tag;
    logic [LW-1:0] evict_line;
    logic          evict_dirty;
    logic          evict_ack;
    logic          mem_req;
    logic          mem_req_write;
    logic [TW-1:0] mem_req_tag;
    logic [LW-1:0] mem_req_wdata;
    logic          mem_resp_valid;
    logic [2:0]    dbg_state;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    victim_cache_controller #(.TAG_WIDTH(TW), .LINE_BYTES(16), .NUM_WAYS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .probe_valid(probe_valid), .probe_tag(probe_tag),
        .probe_hit(probe_hit), .probe_line(probe_line), .probe_ready(probe_ready),
        .evict_valid(evict_valid), .evict_tag(evict_tag), .evict_line(evict_line),
        .evict_dirty(evict_dirty), .evict_ack(evict_ack),
        .mem_req(mem_req), .mem_req_write(mem_req_write), .mem_req_tag(mem_req_tag),
        .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
        .o_dbg_state(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a wait escapes its budget
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [LW-1:0] pat(input logic [TW-1:0] t);
        return {8'hA5, {6{t}}};
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_evict(input logic [TW-1:0] t, input logic [LW-1:0] d, input logic dirty);
        evict_valid = 1'b1; evict_tag = t; evict_line = d; evict_dirty = dirty;
        @(negedge clk);
        evict_valid = 1'b0; evict_tag = '0; evict_line = '0; evict_dirty = 1'b0;
    endtask

    task automatic pulse_probe(input logic [TW-1:0] t);
        probe_valid = 1'b1; probe_tag = t;
        @(negedge clk);
        probe_valid = 1'b0; probe_tag = '0;
    endtask

    task automatic wait_ack(output int cyc, output bit saw_mem);
        cyc = 0; saw_mem = 1'b0;
        while (evict_ack !== 1'b1 && cyc < BUDGET) begin
            if (mem_req) saw_mem = 1'b1;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (probe_ready !== 1'b1 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Clean or dirty install into a cache that needs no write-back
    task automatic install(input string name, input logic [TW-1:0] t, input logic [LW-1:0] d,
                           input logic dirty);
        int c; bit m;
        pulse_evict(t, d, dirty);
        wait_ack(c, m);
        chk({name, "_ack"}, evict_ack, 1);
        chk({name, "_nomem"}, m, 0);
        @(negedge clk);
    endtask

    task automatic probe(input string name, input logic [TW-1:0] t, input logic exp_hit,
                         input logic [LW-1:0] exp_line);
        int c;
        pulse_probe(t);
        wait_ready(c);
        chk({name, "_ready"}, probe_ready, 1);
        chk({name, "_hit"}, probe_hit, exp_hit);
        chk({name, "_line"}, probe_line, exp_line);
        @(negedge clk);
    endtask

    // Directed sequence
    initial begin
        int  c;
        int  c2;
        bit  m;
        int  ready_at;
        int  ack_at;
        int  acks;
        logic ready_hit;
        logic [LW-1:0] ready_line;

        rst_n = 1'b0;
        probe_valid = 1'b0; probe_tag = '0;
        evict_valid = 1'b0; evict_tag = '0; evict_line = '0; evict_dirty = 1'b0;
        mem_resp_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_probe_ready", probe_ready, 0);
        chk("rst_probe_hit", probe_hit, 0);
        chk("rst_probe_line", probe_line, 0);
        chk("rst_evict_ack", evict_ack, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_write", mem_req_write, 0);
        chk("rst_mem_tag", mem_req_tag, 0);
        chk("rst_mem_wdata", mem_req_wdata, 0);
        chk("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic install, hit with invalidate, then miss
        pulse_evict(20'd1, 128'd1, 1'b0);
        wait_ack(c, m);
        chk("t1_ack", evict_ack, 1);
        chk("t1_ack_latency", c, 2);
        chk("t1_nomem", m, 0);
        @(negedge clk);
        chk("t1_ack_pulse", evict_ack, 0);
        pulse_probe(20'd1);
        wait_ready(c);
        chk("t1_ready", probe_ready, 1);
        chk("t1_ready_latency", c, 1);
        chk("t1_hit", probe_hit, 1);
        chk("t1_line", probe_line, 128'd1);
        @(negedge clk);
        chk("t1_ready_pulse", probe_ready, 0);
        chk("t1_line_idle", probe_line, 0);
        probe("t1_reprobe", 20'd1, 1'b0, 128'd0);

        // Dirty victim write-back
        do_reset();
        install("t2_i10", 20'd10, 128'd10, 1'b1);
        install("t2_i11", 20'd11, 128'd11, 1'b0);
        install("t2_i12", 20'd12, 128'd12, 1'b0);
        install("t2_i13", 20'd13, 128'd13, 1'b0);
        pulse_evict(20'd99, 128'd99, 1'b0);
        c = 0;
        while (mem_req !== 1'b1 && c < BUDGET) begin
            @(negedge clk);
            c++;
        end
        chk("t2_mem_req", mem_req, 1);
        chk("t2_mem_write", mem_req_write, 1);
        chk("t2_mem_tag", mem_req_tag, 20'd10);
        chk("t2_mem_wdata", mem_req_wdata, 128'd10);
        chk("t2_no_early_ack", evict_ack, 0);
        repeat (3) @(negedge clk);
        chk("t2_mem_hold", mem_req, 1);
        chk("t2_mem_hold_tag", mem_req_tag, 20'd10);
        chk("t2_hold_no_ack", evict_ack, 0);
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("t2_mem_drop", mem_req, 0);
        chk("t2_mem_drop_tag", mem_req_tag, 0);
        chk("t2_mem_drop_wdata", mem_req_wdata, 0);
        chk("t2_ack", evict_ack, 1);
        @(negedge clk);
        probe("t2_p99", 20'd99, 1'b1, 128'd99);
        probe("t2_p10", 20'd10, 1'b0, 128'd0);
        probe("t2_p11", 20'd11, 1'b1, 128'd11);

        // Clean replacement never touches memory
        do_reset();
        for (int i = 0; i < 4; i++) install("t3_fill", 20'(20 + i), pat(20'(20 + i)), 1'b0);
        install("t3_fifth", 20'd24, pat(20'd24), 1'b0);
        probe("t3_p20", 20'd20, 1'b0, 128'd0);
        probe("t3_p21", 20'd21, 1'b1, pat(20'd21));
        probe("t3_p24", 20'd24, 1'b1, pat(20'd24));

        // Probe one cycle after an evict is serviced before the install
        do_reset();
        install("t4_i50", 20'd50, pat(20'd50), 1'b0);
        evict_valid = 1'b1; evict_tag = 20'd77; evict_line = pat(20'd77); evict_dirty = 1'b0;
        @(negedge clk);
        evict_valid = 1'b0; evict_tag = '0; evict_line = '0;
        probe_valid = 1'b1; probe_tag = 20'd50;
        @(negedge clk);
        probe_valid = 1'b0; probe_tag = '0;
        ready_at = -1; ack_at = -1; ready_hit = 1'b0; ready_line = '0;
        for (int k = 0; k < BUDGET; k++) begin
            if (probe_ready === 1'b1 && ready_at < 0) begin
                ready_at = k; ready_hit = probe_hit; ready_line = probe_line;
            end
            if (evict_ack === 1'b1 && ack_at < 0) ack_at = k;
            @(negedge clk);
        end
        chk("t4_ready_seen", ready_at >= 0, 1);
        chk("t4_ack_seen", ack_at >= 0, 1);
        chk("t4_order", ready_at < ack_at, 1);
        chk("t4_hit", ready_hit, 1);
        chk("t4_line", ready_line, pat(20'd50));
        probe("t4_p77", 20'd77, 1'b1, pat(20'd77));
        probe("t4_p50", 20'd50, 1'b0, 128'd0);

        // Back-to-back probes and back-to-back evicts
        do_reset();
        install("t5_i300", 20'd300, pat(20'd300), 1'b0);
        install("t5_i301", 20'd301, pat(20'd301), 1'b1);
        probe("t5_p300", 20'd300, 1'b1, pat(20'd300));
        probe("t5_p301", 20'd301, 1'b1, pat(20'd301));
        evict_valid = 1'b1; evict_tag = 20'd500; evict_line = pat(20'd500); evict_dirty = 1'b0;
        @(negedge clk);
        evict_tag = 20'd501; evict_line = pat(20'd501); evict_dirty = 1'b1;
        @(negedge clk);
        evict_valid = 1'b0; evict_tag = '0; evict_line = '0; evict_dirty = 1'b0;
        acks = 0; c2 = 0;
        for (int k = 0; k < 30; k++) begin
            if (evict_ack === 1'b1) acks++;
            if (mem_req === 1'b1) c2++;
            @(negedge clk);
        end
        chk("t5_two_acks", acks, 2);
        chk("t5_nomem", c2, 0);
        probe("t5_p500", 20'd500, 1'b1, pat(20'd500));
        probe("t5_p501", 20'd501, 1'b1, pat(20'd501));

        // Second fill of four displaces the first fill entirely
        do_reset();
        for (int i = 0; i < 4; i++) install("t6_a", 20'(600 + i), pat(20'(600 + i)), 1'b0);
        for (int i = 0; i < 4; i++) install("t6_b", 20'(700 + i), pat(20'(700 + i)), 1'b0);
        for (int i = 0; i < 4; i++) probe("t6_old", 20'(600 + i), 1'b0, 128'd0);
        for (int i = 0; i < 4; i++) probe("t6_new", 20'(700 + i), 1'b1, pat(20'(700 + i)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
